weighted_rr_arbiter: RTL

Parametrised weighted round-robin arbiter with a grant/acknowledge handshake, the successor to the plain round-robin arbiter used in core resource sharing (register-file write ports, memory-port and bus masters). Each requester carries a programmable weight that sets how many consecutive acknowledged transfers it may win before priority rotates. Grants are registered and held stable until acknowledged. Requests that are abandoned mid-grant are released without stalling other requesters.

---
 rtl/weighted_rr_arbiter_pkg.sv | 19 +
 rtl/weighted_rr_arbiter_picker.sv | 41 ++++
 rtl/weighted_rr_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/weighted_rr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
//   arb_state_e : arbiter FSM state (IDLE / GRANT)
//   cyc_inc     : cyclic index increment, wrapping at num-1 back to 0
package weighted_rr_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Wrap is an explicit compare so non-power-of-two counts never overflow into unused indices.
  function automatic int unsigned cyc_inc(input int unsigned idx, input int unsigned num);
    if (idx >= num - 32'd1) begin
      return 32'd0;
    end
    return idx + 32'd1;
  endfunction

endpackage

// File: rtl/weighted_rr_arbiter_picker.sv
// Combinational cyclic priority picker.
//   req_i    : request vector
//   start_i  : highest-priority index for this scan
//   onehot_o : one-hot of the first requester found scanning start_i, start_i+1, ...
//   idx_o    : index of that requester
//   found_o  : any request present
module cyclic_priority_picker
  import weighted_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  // Walk the ring from start_i; inner loop keeps every bit select constant.
  always_comb begin
    logic [IDX_W-1:0] v_idx;
    logic             v_found;
    onehot_o = '0;
    idx_o    = '0;
    v_found  = 1'b0;
    v_idx    = start_i;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!v_found && (v_idx == IDX_W'(j)) && req_i[j]) begin
          v_found     = 1'b1;
          idx_o       = IDX_W'(j);
          onehot_o[j] = 1'b1;
        end
      end
      v_idx = IDX_W'(cyc_inc(32'(v_idx), NUM_REQ));
    end
    found_o = v_found;
  end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter with registered grant/ack handshake.
//   clk_i, srst_i : clock, synchronous active-high reset
//   allow_i       : permit new grants (held grants are never revoked)
//   req_i         : request lines, held until acknowledged
//   weight_i      : packed per-requester weights, sampled at grant time
//   ack_i         : consumer accepts the current grant
//   gnt_o         : registered one-hot grant
//   gnt_idx_o     : index of granted requester
//   gnt_valid_o   : |gnt_o
module weighted_rr_arbiter
  import weighted_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned WEIGHT_W = 4,
  parameter int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic                         allow_i,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*WEIGHT_W-1:0]  weight_i,
  input  logic                         ack_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic [IDX_W-1:0]             gnt_idx_o,
  output logic                         gnt_valid_o
);

  arb_state_e          r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_owner;
  logic [WEIGHT_W-1:0] r_credit;
  logic [NUM_REQ-1:0]  r_gnt;

  arb_state_e          w_state_nxt;
  logic [IDX_W-1:0]    w_ptr_nxt;
  logic [IDX_W-1:0]    w_owner_nxt;
  logic [WEIGHT_W-1:0] w_credit_nxt;
  logic [NUM_REQ-1:0]  w_gnt_nxt;

  logic                w_own_req;
  logic [NUM_REQ-1:0]  w_req_masked;
  logic [NUM_REQ-1:0]  w_pick_req;
  logic [IDX_W-1:0]    w_owner_inc;
  logic [IDX_W-1:0]    w_pick_start;
  logic [NUM_REQ-1:0]  w_pick_oh;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_found;
  logic [WEIGHT_W-1:0] w_pick_w;
  logic [WEIGHT_W-1:0] w_pick_credit;

  // r_gnt doubles as the owner's one-hot while in GRANT.
  assign w_own_req    = |(req_i & r_gnt);
  assign w_req_masked = req_i & ~r_gnt;
  assign w_owner_inc  = IDX_W'(cyc_inc(32'(r_owner), NUM_REQ));

  // On release the owner competes only when nobody else is requesting.
  assign w_pick_req   = (r_state == ST_GRANT) ? ((|w_req_masked) ? w_req_masked : req_i) : req_i;
  assign w_pick_start = (r_state == ST_GRANT) ? w_owner_inc : r_ptr;

  cyclic_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i    (w_pick_req),
    .start_i  (w_pick_start),
    .onehot_o (w_pick_oh),
    .idx_o    (w_pick_idx),
    .found_o  (w_pick_found)
  );

  // Weight of the picked requester; zero weight behaves as one.
  always_comb begin
    w_pick_w = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_pick_idx == IDX_W'(i)) begin
        w_pick_w = weight_i[i*WEIGHT_W +: WEIGHT_W];
      end
    end
    w_pick_credit = (w_pick_w == '0) ? WEIGHT_W'(1) : w_pick_w;
  end

  // Next-state and datapath decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_owner_nxt  = r_owner;
    w_credit_nxt = r_credit;
    w_gnt_nxt    = r_gnt;
    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt = '0;
        if (allow_i && w_pick_found) begin
          w_state_nxt  = ST_GRANT;
          w_gnt_nxt    = w_pick_oh;
          w_owner_nxt  = w_pick_idx;
          w_credit_nxt = w_pick_credit;
        end
      end
      ST_GRANT: begin
        if (ack_i && w_own_req && allow_i && (r_credit > WEIGHT_W'(1))) begin
          w_credit_nxt = r_credit - WEIGHT_W'(1);
        end else if (ack_i || !w_own_req) begin
          // Release: rotate priority past the owner and hand over without a bubble.
          w_ptr_nxt = w_owner_inc;
          if (allow_i && w_pick_found) begin
            w_gnt_nxt    = w_pick_oh;
            w_owner_nxt  = w_pick_idx;
            w_credit_nxt = w_pick_credit;
          end else begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_credit <= '0;
      r_gnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_owner  <= w_owner_nxt;
      r_credit <= w_credit_nxt;
      r_gnt    <= w_gnt_nxt;
    end
  end

  assign gnt_o       = r_gnt;
  assign gnt_idx_o   = r_owner;
  assign gnt_valid_o = |r_gnt;

endmodule
